// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg -- shared constants, types and helpers for the counter block.
// ---------------------------------------------------------------------------
package counter_pkg;

    // Default and maximum supported count register widths.
    localparam int unsigned COUNTER_DEFAULT_WIDTH = 4;
    localparam int unsigned COUNTER_MAX_WIDTH     = 32;

    // Count value at the default width.
    typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

    // Counting direction, derived from the DOWN parameter.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Value at which the counter wraps on the next edge:
    // MAX_COUNT when counting up, zero when counting down.
    function automatic logic [31:0] term_value(input logic down,
                                               input logic [31:0] max_count);
        return down ? 32'd0 : max_count;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_bin2gray.sv
// ---------------------------------------------------------------------------
// counter_bin2gray -- purely combinational binary to Gray code converter.
// Only instantiated by counter when COUNTER_GRAY_EN is defined.
// ---------------------------------------------------------------------------
module counter_bin2gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_bin,
    output logic [WIDTH-1:0] o_gray
);

    // Each Gray bit is the XOR of a binary bit and its upper neighbour.
    always_comb begin
        o_gray = i_bin ^ (i_bin >> 1);
    end

endmodule : counter_bin2gray

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter -- free-running modulo (MAX_COUNT+1) up/down counter.
//
// Counts on every rising clk edge, wrapping at MAX_COUNT (up) or 0 (down).
// at_term is a zero-latency decode of the count; wrap is a registered pulse
// in the cycle that holds the post-wrap value. rst is asynchronous,
// active-high.
//
// Optional feature: define COUNTER_GRAY_EN to add the count_gray output, a
// registered Gray-coded copy of count with identical timing.
// ---------------------------------------------------------------------------
module counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = COUNTER_DEFAULT_WIDTH,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter bit              DOWN      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             wrap
`ifdef COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] count_gray
`endif
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > COUNTER_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "counter: WIDTH=%0d outside legal range 1..%0d",
               WIDTH, COUNTER_MAX_WIDTH);
    end

    if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $fatal(1, "counter: MAX_COUNT=%0d outside legal range 1..2**%0d-1",
               MAX_COUNT, WIDTH);
    end

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    localparam logic [WIDTH-1:0] LIMIT   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] TERM    = WIDTH'(term_value(DOWN, 32'(MAX_COUNT)));
    localparam logic [WIDTH-1:0] RST_VAL = DOWN ? LIMIT : '0;
    localparam dir_e             DIR     = DOWN ? DIR_DOWN : DIR_UP;

    // -----------------------------------------------------------------------
    // State and next-state signals
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_count_next;
    logic             w_is_term;

    // Wrap is decided by comparing against the terminal value rather than by
    // natural overflow, so non-power-of-two moduli behave correctly.
    assign w_is_term = (r_count == TERM);

    // Next count: one step in the configured direction, reloading at terminal.
    always_comb begin
        w_count_next = RST_VAL;
        case (DIR)
            DIR_UP:   w_count_next = w_is_term ? '0    : r_count + WIDTH'(1);
            DIR_DOWN: w_count_next = w_is_term ? LIMIT : r_count - WIDTH'(1);
            default:  w_count_next = RST_VAL;
        endcase
    end

    // Count register and wrap pulse; wrap goes high in the cycle after the
    // count sat at its terminal value, i.e. while it holds the wrapped value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_wrap  <= w_is_term;
        end
    end

    assign count   = r_count;
    assign at_term = w_is_term;
    assign wrap    = r_wrap;

`ifdef COUNTER_GRAY_EN
    // -----------------------------------------------------------------------
    // Registered Gray-coded count
    // -----------------------------------------------------------------------
    localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

    logic [WIDTH-1:0] w_gray_next;
    logic [WIDTH-1:0] r_gray;

    counter_bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .i_bin  (w_count_next),
        .o_gray (w_gray_next)
    );

    // Gray register converts the next binary count so it updates on the same
    // edge as count rather than one cycle behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray <= RST_GRAY;
        end else begin
            r_gray <= w_gray_next;
        end
    end

    assign count_gray = r_gray;
`endif

endmodule : counter

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter -- self-checking bench for counter.
// Three instances: default up counter (mod 16), down counter with
// MAX_COUNT=9, and a 5-bit up counter with MAX_COUNT=20. A modular-arithmetic
// reference model predicts count, at_term and wrap. Define COUNTER_GRAY_EN to
// also check count_gray.
// ---------------------------------------------------------------------------
module tb_counter;

    logic       clk;
    logic       rst;

    logic [3:0] c_up;
    logic       t_up, w_up;
    logic [3:0] c_dn;
    logic       t_dn, w_dn;
    logic [4:0] c_nb;
    logic       t_nb, w_nb;
`ifdef COUNTER_GRAY_EN
    logic [3:0] g_up, g_dn;
    logic [4:0] g_nb;
`endif

    counter dut_up (
        .clk     (clk),
        .rst     (rst),
        .count   (c_up),
        .at_term (t_up),
        .wrap    (w_up)
`ifdef COUNTER_GRAY_EN
        , .count_gray (g_up)
`endif
    );

    counter #(
        .WIDTH     (4),
        .MAX_COUNT (9),
        .DOWN      (1'b1)
    ) dut_dn (
        .clk     (clk),
        .rst     (rst),
        .count   (c_dn),
        .at_term (t_dn),
        .wrap    (w_dn)
`ifdef COUNTER_GRAY_EN
        , .count_gray (g_dn)
`endif
    );

    counter #(
        .WIDTH     (5),
        .MAX_COUNT (20),
        .DOWN      (1'b0)
    ) dut_nb (
        .clk     (clk),
        .rst     (rst),
        .count   (c_nb),
        .at_term (t_nb),
        .wrap    (w_nb)
`ifdef COUNTER_GRAY_EN
        , .count_gray (g_nb)
`endif
    );

    // Reference model: one entry per instance.
    longint unsigned mx [3] = '{15, 9, 20};
    bit              dn [3] = '{1'b0, 1'b1, 1'b0};
    longint unsigned m  [3];
    bit              mw [3];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned wraps_seen;
    int unsigned wraps_exp;

    task automatic check(input string tag, input longint unsigned obs,
                         input longint unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m[i]  = dn[i] ? mx[i] : 0;
            mw[i] = 1'b0;
        end
    endtask

    // Advance modulo (MAX+1); a wrap is any step where the value moved
    // against the counting direction.
    task automatic model_step();
        longint unsigned old;
        for (int i = 0; i < 3; i++) begin
            old   = m[i];
            m[i]  = dn[i] ? (old + mx[i]) % (mx[i] + 1) : (old + 1) % (mx[i] + 1);
            mw[i] = dn[i] ? (m[i] > old) : (m[i] < old);
        end
    endtask

    function automatic longint unsigned term_of(input int i);
        return dn[i] ? 0 : mx[i];
    endfunction

    function automatic longint unsigned gray_of(input longint unsigned v);
        return v ^ (v >> 1);
    endfunction

    task automatic check_all();
        check("up.count", c_up, m[0]);
        check("up.at_term", t_up, m[0] == term_of(0));
        check("up.wrap", w_up, mw[0]);
        check("dn.count", c_dn, m[1]);
        check("dn.at_term", t_dn, m[1] == term_of(1));
        check("dn.wrap", w_dn, mw[1]);
        check("nb.count", c_nb, m[2]);
        check("nb.at_term", t_nb, m[2] == term_of(2));
        check("nb.wrap", w_nb, mw[2]);
`ifdef COUNTER_GRAY_EN
        check("up.gray", g_up, gray_of(m[0]));
        check("dn.gray", g_dn, gray_of(m[1]));
        check("nb.gray", g_nb, gray_of(m[2]));
`endif
    endtask

    // One full clock period; checks #1 after the rising edge.
    task automatic tick();
        #5 clk = 1'b1;
        if (!rst) model_step();
        #1;
        check_all();
        if (w_up) wraps_seen++;
        if (mw[0]) wraps_exp++;
        #4 clk = 1'b0;
    endtask

    // Assert reset between edges, hold it over n edges, release between edges.
    task automatic areset(input int unsigned n);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int unsigned k = 0; k < n; k++) tick();
        #2 rst = 1'b0;
        #1;
        check_all();
    endtask

    // Hold clk high, then low, for long stretches: no state change expected.
    task automatic hold_levels();
        #5 clk = 1'b1;
        if (!rst) model_step();
        #1;
        check_all();
        #37;
        check_all();
        clk = 1'b0;
        #29;
        check_all();
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        wraps_seen = 0;
        wraps_exp  = 0;
        model_reset();
        #3;
        check_all();

        // Reset held across 30 rising edges.
        for (int unsigned k = 0; k < 30; k++) tick();
        check("rst_hold.count", c_up, 0);
        check("rst_hold.dn_count", c_dn, 9);
        #2 rst = 1'b0;
        #1;
        check_all();

        // 16 edges from reset: 1..15 then 0; down counter 8..0,9,...
        wraps_seen = 0;
        wraps_exp  = 0;
        for (int unsigned k = 0; k < 15; k++) tick();
        check("seq.at15", c_up, 15);
        check("seq.term15", t_up, 1);
        tick();
        check("seq.wrap_to0", c_up, 0);
        check("seq.wrap_pulse", w_up, 1);
        check("seq.wraps", wraps_seen, 1);

        // Async reset while count=9 abandons the sequence, no wrap pulse.
        areset(0);
        for (int unsigned k = 0; k < 9; k++) tick();
        check("mid.at9", c_up, 9);
        areset(0);
        check("mid.count0", c_up, 0);
        check("mid.nowrap", w_up, 0);

        // 24 edges after reset: count 8, exactly one wrap pulse.
        wraps_seen = 0;
        wraps_exp  = 0;
        for (int unsigned k = 0; k < 24; k++) tick();
        check("t24.count", c_up, 8);
        check("t24.wraps", wraps_seen, wraps_exp);
        check("t24.wraps_one", wraps_seen, 1);

        // Long clock levels without edges.
        hold_levels();

        // Randomized mix of edges, held levels and async resets.
        for (int unsigned it = 0; it < 600; it++) begin
            case ($urandom_range(0, 24))
                0:       areset($urandom_range(0, 3));
                1:       hold_levels();
                default: tick();
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_counter

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4, is the count register width in bits (legal range 1..32).
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1, is the terminal count value (legal range 1..2**WIDTH-1).
REQ-003 Parameter DOWN, default 0: 0 = count up, 1 = count down.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port count, output, WIDTH bits: current count value, driven directly from a register.
REQ-007 Port at_term, output, 1 bit: high while count equals the terminal value (MAX_COUNT when DOWN=0, 0 when DOWN=1).
REQ-008 Port wrap, output, 1 bit: registered one-cycle pulse, high in the cycle immediately after a wrap.
REQ-009 Outputs may be left unconnected; the module has no further inputs, so a clk/rst/count-only instantiation is fully functional.

Function
REQ-010 With rst low, count SHALL change by exactly 1 on every clk rising edge (+1 if DOWN=0, -1 if DOWN=1); there is no enable or hold state.
REQ-011 Up mode wraps MAX_COUNT -> 0; down mode wraps 0 -> MAX_COUNT; count SHALL never leave the range 0..MAX_COUNT.
REQ-012 Defaults: count sequence 0,1,...,15,0 with modulus 16, wrapping on the 16th edge after reset release.
REQ-013 at_term SHALL be combinational from count, with zero latency.
REQ-014 wrap SHALL be high for exactly one cycle, in the cycle where count holds the post-wrap value, and low otherwise.
REQ-015 Arithmetic SHALL be WIDTH bits wide, and the wrap SHALL be decided by compare-to-terminal, never by natural overflow, so non-power-of-two MAX_COUNT works.
REQ-016 Clock levels without a rising edge, including glitches or held levels on clk, SHALL NOT change state.

Reset
REQ-017 rst high SHALL immediately, without waiting for a clk edge, force count to 0 in up mode or MAX_COUNT in down mode, and force wrap to 0.
REQ-018 While rst is held high, outputs SHALL stay at their reset values regardless of any clk activity.
REQ-019 After rst deasserts, the first clk rising edge SHALL advance count by one step from the reset value.
REQ-020 Reset asserted mid-count SHALL abandon the sequence; no wrap pulse is generated by reset.

Configuration
REQ-021 Macro COUNTER_GRAY_EN: when defined, the module SHALL add output count_gray, WIDTH bits, equal to the registered Gray code of count (bin ^ (bin >> 1)) with the same timing as count; reset value is the Gray code of the count reset value.
REQ-022 Without COUNTER_GRAY_EN, the count_gray port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-023 Package counter_pkg SHALL hold the default width constant (4), the typedef count_t (logic [3:0]) and the function term_value(DOWN, MAX_COUNT).
REQ-024 One sub-module, counter_bin2gray (parameter WIDTH, purely combinational), SHALL be instantiated only under COUNTER_GRAY_EN.
REQ-025 Parameters SHALL be checked at elaboration; an illegal WIDTH or MAX_COUNT SHALL be a fatal elaboration error.

Verification
REQ-026 Hold rst=1 for 30 clk edges -> count stays 0, wrap stays 0 throughout.
REQ-027 Release rst, then apply 16 rising edges -> count 1..15 then 0; at_term high only at 15; wrap high only in the cycle count returns to 0.
REQ-028 Assert rst between edges while count=9 -> count becomes 0 before the next edge; no wrap pulse occurs.
REQ-029 Toggle clk 48 times (24 rising edges) after reset -> count=8 at the end, with exactly one wrap pulse.
REQ-030 With MAX_COUNT=9, DOWN=1: reset -> count=9; 10 edges -> 8..0,9, with wrap high once at the 0->9 transition.
REQ-031 With COUNTER_GRAY_EN defined: at count=5, count_gray=4'b0111; at count=15, count_gray=4'b1000.
